// File: rtl/cfr_pkg.sv
// cfr_pkg -- shared types and constants for the CFR peak detector.
//   HOLDOFF_WIDTH    : width of the holdoff counter and of ctrl_holdoff.
//   PEAK_MAG_WIDTH   : peak_delta width at the default DATA_WIDTH (16 + 1).
//   PEAK_THETA_WIDTH : peak_theta width at the default THETA_WIDTH.
//   peak_rec_t       : registered peak record (delta above threshold, phase).
package cfr_pkg;

  localparam int HOLDOFF_WIDTH    = 8;
  localparam int PEAK_MAG_WIDTH   = 17;
  localparam int PEAK_THETA_WIDTH = 8;

  typedef struct packed {
    logic [PEAK_MAG_WIDTH-1:0]   delta;
    logic [PEAK_THETA_WIDTH-1:0] theta;
  } peak_rec_t;

endpackage

// File: rtl/cdc_array_single.sv
// cdc_array_single -- per-bit multi-flop synchronizer for quasi-static buses.
//   Parameters: DEST_SYNC_FF (flop stages, >= 2), WIDTH (bus width).
//   Ports: dest_clk (destination clock), src_in (asynchronous source bus),
//          dest_out (bus synchronized into dest_clk).
// No reset: the chain flushes itself within DEST_SYNC_FF cycles.
module cdc_array_single #(
  parameter int DEST_SYNC_FF = 2,
  parameter int WIDTH        = 1
) (
  input  logic             dest_clk,
  input  logic [WIDTH-1:0] src_in,
  output logic [WIDTH-1:0] dest_out
);

  logic [WIDTH-1:0] sync_q [DEST_SYNC_FF];

  always_ff @(posedge dest_clk) begin
    sync_q[0] <= src_in;
    for (int i = 1; i < DEST_SYNC_FF; i++) begin
      sync_q[i] <= sync_q[i-1];
    end
  end

  assign dest_out = sync_q[DEST_SYNC_FF-1];

endmodule

// File: rtl/cfr_peak_window.sv
// cfr_peak_window -- 3-sample magnitude window and local-maximum compare.
//   Parameters: DATA_WIDTH (magnitude is DATA_WIDTH+1 bits), THETA_WIDTH.
//   Ports: clk, rst (sync, active-high), enable (synchronized detect enable),
//          data_valid/data_r/data_theta (incoming sample = "next"),
//          threshold, holdoff_idle (holdoff counter is zero),
//          hit (combinational: cur is a peak, decided as next is accepted),
//          delta (cur - threshold), theta (phase of the peak sample).
// prev and cur are registered; "next" is the sample presented this cycle,
// so the decision for cur is made in the very cycle its successor arrives.
module cfr_peak_window #(
  parameter int DATA_WIDTH  = 16,
  parameter int THETA_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   data_valid,
  input  logic [DATA_WIDTH:0]    data_r,
  input  logic [THETA_WIDTH-1:0] data_theta,
  input  logic [DATA_WIDTH:0]    threshold,
  input  logic                   holdoff_idle,
  output logic                   hit,
  output logic [DATA_WIDTH:0]    delta,
  output logic [THETA_WIDTH-1:0] theta
);

  logic [DATA_WIDTH:0]    prev_q;
  logic [DATA_WIDTH:0]    cur_q;
  logic [THETA_WIDTH-1:0] cur_theta_q;

  // Empty slots read 0, so a freshly cleared window behaves as if preceded
  // by zero-magnitude samples. The phase is only reloaded when the magnitude
  // changes: across a plateau cur keeps the phase of the plateau's first
  // sample, which is the one reported once the plateau falls off.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      prev_q      <= '0;
      cur_q       <= '0;
      cur_theta_q <= '0;
    end else if (data_valid) begin
      prev_q <= cur_q;
      cur_q  <= data_r;
      if (data_r != cur_q) begin
        cur_theta_q <= data_theta;
      end
    end
  end

  // Stage 0: decision for cur, made as its successor is accepted.
  always_comb begin
    hit   = data_valid && enable && holdoff_idle &&
            (cur_q > threshold) && (cur_q >= prev_q) && (cur_q > data_r);
    delta = cur_q - threshold;
    theta = cur_theta_q;
  end

endmodule

// File: rtl/cfr_peak_detect.sv
// cfr_peak_detect -- crest-factor-reduction peak detector on polar samples.
//   Parameters: DATA_WIDTH (magnitude is DATA_WIDTH+1 bits), THETA_WIDTH.
//   Ports: clk, rst (sync, active-high),
//          data_valid_in/data_r_in/data_theta_in : input sample stream,
//          ctrl_enable/ctrl_threshold/ctrl_holdoff : quasi-static controls,
//            each resynchronized into clk through a 2-flop cdc_array_single,
//          peak_valid (1-cycle strobe), peak_delta (magnitude - threshold),
//          peak_theta (phase of the peak); delta/theta hold between peaks.
//   Optional macro CFR_PEAK_DETECT_STATS_EN adds stat_clear (input) and
//   stat_peak_count (saturating 32-bit count of reported peaks).
module cfr_peak_detect
  import cfr_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int THETA_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     data_valid_in,
  input  logic [DATA_WIDTH:0]      data_r_in,
  input  logic [THETA_WIDTH-1:0]   data_theta_in,
  input  logic                     ctrl_enable,
  input  logic [DATA_WIDTH:0]      ctrl_threshold,
  input  logic [HOLDOFF_WIDTH-1:0] ctrl_holdoff,
  output logic                     peak_valid,
  output logic [DATA_WIDTH:0]      peak_delta,
  output logic [THETA_WIDTH-1:0]   peak_theta
`ifdef CFR_PEAK_DETECT_STATS_EN
  ,
  input  logic                     stat_clear,
  output logic [31:0]              stat_peak_count
`endif
);

  logic                     en_s;
  logic [DATA_WIDTH:0]      thr_s;
  logic [HOLDOFF_WIDTH-1:0] hold_s;

  cdc_array_single #(.DEST_SYNC_FF(2), .WIDTH(1)) u_sync_en (
    .dest_clk (clk),
    .src_in   (ctrl_enable),
    .dest_out (en_s)
  );

  cdc_array_single #(.DEST_SYNC_FF(2), .WIDTH(DATA_WIDTH+1)) u_sync_thr (
    .dest_clk (clk),
    .src_in   (ctrl_threshold),
    .dest_out (thr_s)
  );

  cdc_array_single #(.DEST_SYNC_FF(2), .WIDTH(HOLDOFF_WIDTH)) u_sync_hold (
    .dest_clk (clk),
    .src_in   (ctrl_holdoff),
    .dest_out (hold_s)
  );

  logic [HOLDOFF_WIDTH-1:0] holdoff_cnt;
  logic                     hit_p0;
  logic [DATA_WIDTH:0]      delta_p0;
  logic [THETA_WIDTH-1:0]   theta_p0;

  cfr_peak_window #(
    .DATA_WIDTH  (DATA_WIDTH),
    .THETA_WIDTH (THETA_WIDTH)
  ) u_window (
    .clk          (clk),
    .rst          (rst),
    .enable       (en_s),
    .data_valid   (data_valid_in),
    .data_r       (data_r_in),
    .data_theta   (data_theta_in),
    .threshold    (thr_s),
    .holdoff_idle (holdoff_cnt == '0),
    .hit          (hit_p0),
    .delta        (delta_p0),
    .theta        (theta_p0)
  );

  // Stage 1: registered peak strobe and record.
  logic      vld_p1;
  peak_rec_t rec_p1;

  // The holdoff load on a report wins over the per-sample decrement; a
  // loaded value of 0 leaves the counter idle, disabling holdoff.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      rec_p1      <= '0;
      holdoff_cnt <= '0;
    end else begin
      vld_p1 <= hit_p0;
      if (hit_p0) begin
        rec_p1 <= '{delta: delta_p0, theta: theta_p0};
      end
      if (!en_s) begin
        holdoff_cnt <= '0;
      end else if (hit_p0) begin
        holdoff_cnt <= hold_s;
      end else if (data_valid_in && (holdoff_cnt != '0)) begin
        holdoff_cnt <= holdoff_cnt - 1'b1;
      end
    end
  end

  assign peak_valid = vld_p1;
  assign peak_delta = rec_p1.delta;
  assign peak_theta = rec_p1.theta;

`ifdef CFR_PEAK_DETECT_STATS_EN
  logic [31:0] stat_cnt_q;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Clear has priority over a coincident increment.
  always_ff @(posedge clk) begin
    if (rst || stat_clear) begin
      stat_cnt_q <= '0;
    end else if (vld_p1) begin
      stat_cnt_q <= sat_inc32(stat_cnt_q);
    end
  end

  assign stat_peak_count = stat_cnt_q;
`endif

endmodule

// File: tb/tb_cfr_peak_detect.sv
// tb_cfr_peak_detect -- directed bench for cfr_peak_detect with a list-based
// reference model checked every cycle, plus literal expectations per scenario.
// Control inputs are only changed while no sample is in flight and are then
// given several cycles to cross the synchronizers before data resumes.
module tb_cfr_peak_detect;

  localparam int DW = 16;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          vin;
  logic [DW:0]   rin;
  logic [TW-1:0] thin;
  logic          en;
  logic [DW:0]   thr;
  logic [7:0]    hold;
  logic          pv;
  logic [DW:0]   pdelta;
  logic [TW-1:0] ptheta;
`ifdef CFR_PEAK_DETECT_STATS_EN
  logic          sclr;
  logic [31:0]   scount;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cfr_peak_detect #(.DATA_WIDTH(DW), .THETA_WIDTH(TW)) dut (
    .clk            (clk),
    .rst            (rst),
    .data_valid_in  (vin),
    .data_r_in      (rin),
    .data_theta_in  (thin),
    .ctrl_enable    (en),
    .ctrl_threshold (thr),
    .ctrl_holdoff   (hold),
    .peak_valid     (pv),
    .peak_delta     (pdelta),
    .peak_theta     (ptheta)
`ifdef CFR_PEAK_DETECT_STATS_EN
    ,
    .stat_clear      (sclr),
    .stat_peak_count (scount)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Keeps the full list of samples accepted since the last clear and decides
  // each peak from that history directly.
  int   hv[$];
  int   ht[$];
  int   acc_idx;
  bit   have_rep;
  int   rep_idx;
  int   rep_hold;
  bit   started = 1'b0;
  logic          exp_v = 1'b0;
  logic [DW:0]   exp_d = '0;
  logic [TW-1:0] exp_t = '0;

  always @(posedge clk) begin
    int n, cur, prv, j, pth;
    bit hold_ok;
    if (rst) begin
      hv.delete(); ht.delete();
      acc_idx = 0; have_rep = 1'b0;
      started <= 1'b1;
      exp_v <= 1'b0; exp_d <= '0; exp_t <= '0;
    end else if (!en) begin
      hv.delete(); ht.delete();
      acc_idx = 0; have_rep = 1'b0;
      exp_v <= 1'b0;
    end else begin
      exp_v <= 1'b0;
      if (vin) begin
        n   = hv.size();
        cur = (n > 0) ? hv[n-1] : 0;
        prv = (n > 1) ? hv[n-2] : 0;
        j = n - 1;
        while (j > 0 && hv[j-1] == cur) j--;
        pth = (n > 0) ? ht[j] : 0;
        hold_ok = !have_rep || (acc_idx - rep_idx > rep_hold);
        if (n > 0 && cur > int'(thr) && cur >= prv && cur > int'(rin) && hold_ok) begin
          exp_v <= 1'b1;
          exp_d <= DW'(cur - int'(thr));
          exp_t <= TW'(pth);
          have_rep = 1'b1;
          rep_idx  = acc_idx;
          rep_hold = int'(hold);
        end
        hv.push_back(int'(rin));
        ht.push_back(int'(thin));
        acc_idx++;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("cyc_peak_valid", 32'(pv), 32'(exp_v));
      chk("cyc_peak_delta", 32'(pdelta), 32'(exp_d));
      chk("cyc_peak_theta", 32'(ptheta), 32'(exp_t));
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input int r, input int th);
    logic [31:0] rv, tv;
    rv = r; tv = th;
    vin = 1'b1; rin = rv[DW:0]; thin = tv[TW-1:0];
    @(posedge clk); #1;
    vin = 1'b0;
  endtask

  task automatic idle(input int n);
    vin = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_peak(input string name, input int v, input int d, input int t);
    chk({name, "_valid"}, 32'(pv), 32'(v));
    chk({name, "_delta"}, 32'(pdelta), 32'(d));
    chk({name, "_theta"}, 32'(ptheta), 32'(t));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; vin = 1'b0; rin = '0; thin = '0;
    en = 1'b1; thr = 17'd1000; hold = 8'd0;
`ifdef CFR_PEAK_DETECT_STATS_EN
    sclr = 1'b0;
`endif
    idle(4);
    rst = 1'b0;
    chk_peak("reset", 0, 0, 0);

    // Threshold boundary: equal is not a peak, one above gives delta 1.
    send(1000, 1); send(0, 2);
    chk_peak("thr_equal", 0, 0, 0);
    send(1001, 3); send(0, 4);
    chk_peak("thr_plus1", 1, 1, 3);
    send(0, 5);
    chk_peak("hold_after_peak", 0, 1, 3);

    // Simple rise/fall peak, reported right after the 900 is accepted.
    send(0, 10); send(500, 11); send(1200, 12); send(900, 13);
    chk_peak("basic", 1, 200, 12);
    send(0, 14);
    chk_peak("basic_after", 0, 200, 12);

    // Plateau: first sample of the plateau is reported.
    send(1500, 20); send(1500, 21);
    chk("plateau_mid_valid", 32'(pv), 32'd0);
    send(1200, 22);
    chk_peak("plateau", 1, 500, 20);
    send(0, 23);

    // Holdoff 3: index 4 suppressed, index 7 reported.
    hold = 8'd3; idle(4);
    send(500, 30); send(1000, 31); send(2000, 32); send(1000, 33);
    chk_peak("holdoff_first", 1, 1000, 32);
    send(2000, 34); send(1000, 35);
    chk("holdoff_suppressed", 32'(pv), 32'd0);
    send(1000, 36); send(2000, 37); send(1000, 38);
    chk_peak("holdoff_repeat", 1, 1000, 37);
    send(0, 39);
    hold = 8'd0; idle(4);

    // Gaps in valid do not change the outcome.
    send(800, 40); idle(2); send(1300, 41); idle(2); send(700, 42);
    chk_peak("gaps", 1, 300, 41);

    // Enable dropped with a peak pending: nothing reported, clean restart.
    send(1300, 50);
    en = 1'b0; idle(2);
    send(0, 0);
    chk("disabled_no_peak", 32'(pv), 32'd0);
    en = 1'b1; idle(4);
    send(1100, 51); send(0, 52);
    chk_peak("reenable", 1, 100, 51);

    // Reset mid-window discards the pending decision.
    send(1500, 60);
    rst = 1'b1; send(0, 61);
    chk_peak("reset_mid", 0, 0, 0);
    rst = 1'b0;
    send(0, 62);
    chk("after_reset_no_peak", 32'(pv), 32'd0);

`ifdef CFR_PEAK_DETECT_STATS_EN
    send(1200, 70); send(0, 71); idle(1);
    chk("stat_count_one", scount, 32'd1);
    force dut.stat_cnt_q = 32'hFFFF_FFFF;
    idle(1);
    release dut.stat_cnt_q;
    send(1200, 72); send(0, 73);
    chk("stat_sat_peak", 32'(pv), 32'd1);
    idle(1);
    chk("stat_saturated", scount, 32'hFFFF_FFFF);
    send(1200, 74); send(0, 75);
    chk("stat_clr_peak", 32'(pv), 32'd1);
    sclr = 1'b1; idle(1); sclr = 1'b0;
    chk("stat_clear_wins", scount, 32'd0);
`endif

    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
